// File: rtl/param_inv_pipe.sv
// ----------------------------------------------------------------------------
// param_inv_pipe
//
// Purpose:
//   Streaming bit-transform pipeline with valid/ready handshakes on both
//   sides. Each accepted word is transformed at entry, according to the mode
//   and mask sampled with it, and then moves through STAGES registered stages.
//   Every stage holds one word and one valid bit. A stage refills in the same
//   cycle that it drains, so the pipeline sustains one word per cycle and
//   stalls without losing words under back-pressure.
//
//   Mode encoding:
//     00 : ~in_data
//     01 :  in_data
//     10 :  in_data ^ mask
//     11 :  all zeros
//
// Optional feature (compile-time macro PARAM_INV_CHGCNT_EN):
//   When the macro is defined, the chg_cnt output counts output transfers
//   whose word differs from the previously transferred word. The previous
//   word is taken as 0 after reset. The count saturates at 2^CNT_W-1.
//   When the macro is undefined, the port and its logic are absent.
//
// Parameters:
//   WIDTH  : data width in bits (1..64)
//   STAGES : pipeline depth in register stages (1..4)
//   CNT_W  : width of the change counter
//
// Ports:
//   clk       in   clock; all state updates on the rising edge
//   rst       in   synchronous active-high reset
//   in_valid  in   upstream word valid
//   in_ready  out  a word is accepted this cycle when in_valid is also 1
//   in_data   in   input word
//   mode      in   operation select, sampled on acceptance
//   mask      in   per-bit invert mask, sampled on acceptance
//   out_valid out  output word valid
//   out_ready in   downstream accepts the output word this cycle
//   out_data  out  transformed word
//   chg_cnt   out  output-change count (only with PARAM_INV_CHGCNT_EN)
// ----------------------------------------------------------------------------
module param_inv_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] mask,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PARAM_INV_CHGCNT_EN
    ,
    output logic [CNT_W-1:0] chg_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Elaboration-time parameter range checks
    // ------------------------------------------------------------------------
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("param_inv_pipe: WIDTH must be in 1..64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("param_inv_pipe: STAGES must be in 1..4");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("param_inv_pipe: CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Stage storage
    // ------------------------------------------------------------------------
    logic [STAGES-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];

    // stage_rdy[k] : stage k can take a new word this cycle.
    // stage_rdy[STAGES] stands for the downstream consumer.
    logic [STAGES:0]   stage_rdy;
    logic [WIDTH-1:0]  xform;
    logic              accept;

    // ------------------------------------------------------------------------
    // Entry transform: computed combinationally from the words being offered
    // ------------------------------------------------------------------------
    always_comb begin
        xform = '0;
        unique case (mode)
            2'b00: xform = ~in_data;
            2'b01: xform = in_data;
            2'b10: xform = in_data ^ mask;
            2'b11: xform = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Ready chain: a stage is free when it is empty or its word moves on this
    // cycle. Evaluated from the output end back to the entry, so a full
    // pipeline accepts a new word in the same cycle the oldest one leaves.
    // ------------------------------------------------------------------------
    always_comb begin
        stage_rdy         = '0;
        stage_rdy[STAGES] = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            stage_rdy[k] = !valid_q[k] || stage_rdy[k+1];
        end
    end

    // in_ready is held low during reset so no word is accepted then.
    assign in_ready = stage_rdy[0] && !rst;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------------
    // Next-state for the stages
    // ------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;

        if (stage_rdy[0]) begin
            valid_d[0] = accept;
            if (accept) begin
                data_d[0] = xform;
            end
        end

        for (int k = 1; k < int'(STAGES); k++) begin
            if (stage_rdy[k]) begin
                valid_d[k] = valid_q[k-1];
                // Data only moves with a valid word, so an empty stage keeps
                // its last contents instead of picking up stale values.
                if (valid_q[k-1]) begin
                    data_d[k] = data_q[k-1];
                end
            end
        end
    end

    // Data is also cleared on reset so out_data reads 0 right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < int'(STAGES); k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

`ifdef PARAM_INV_CHGCNT_EN
    // ------------------------------------------------------------------------
    // Output-change counter
    // ------------------------------------------------------------------------
    logic             out_xfer;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign out_xfer = out_valid && out_ready;

    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (out_xfer) begin
            prev_d = out_data;
            // Saturate: all-ones is the ceiling.
            if (out_data != prev_q && cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            cnt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

    assign chg_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_param_inv_pipe.sv
// ----------------------------------------------------------------------------
// tb_param_inv_pipe
//
// Self-checking bench for param_inv_pipe (WIDTH=8, STAGES=2). Inputs are
// driven 1 time unit after the rising edge; all observation happens on the
// falling edge. Accepted words push their expected result onto a scoreboard
// queue, and output transfers pop and compare against it. Held outputs are
// also checked during every stall. When PARAM_INV_CHGCNT_EN is defined, the
// bench uses CNT_W=2 and tracks the change counter with its own model.
// ----------------------------------------------------------------------------
module tb_param_inv_pipe;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned STAGES = 2;
`ifdef PARAM_INV_CHGCNT_EN
    localparam int unsigned CNT_W  = 2;
`else
    localparam int unsigned CNT_W  = 16;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [1:0]       mode = 2'b00;
    logic [WIDTH-1:0] mask = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
`ifdef PARAM_INV_CHGCNT_EN
    logic [CNT_W-1:0] chg_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] sb[$];

    param_inv_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .mode      (mode),
        .mask      (mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PARAM_INV_CHGCNT_EN
        ,
        .chg_cnt   (chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input logic [1:0] m,
                                               input logic [WIDTH-1:0] k);
        case (m)
            2'b00:   return ~d;
            2'b01:   return d;
            2'b10:   return d ^ k;
            default: return '0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: scoreboard, stall stability and change-count model
    // ------------------------------------------------------------------------
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] held_data  = '0;
    logic [WIDTH-1:0] exp_word;
    int unsigned      m_cnt  = 0;
    logic [WIDTH-1:0] m_prev = '0;

    always @(negedge clk) begin
        if (rst) begin
            check_val("ready_in_rst", {63'd0, in_ready}, 64'd0);
            sb.delete();
            stall_prev = 1'b0;
            m_cnt      = 0;
            m_prev     = '0;
        end else begin
`ifdef PARAM_INV_CHGCNT_EN
            check_val("chg_cnt", {{(64-CNT_W){1'b0}}, chg_cnt}, 64'(m_cnt));
`endif
            if (stall_prev) begin
                check_val("stall_valid", {63'd0, out_valid}, 64'd1);
                check_val("stall_data", {56'd0, out_data}, {56'd0, held_data});
            end
            if (out_valid && out_ready) begin
                check_val("sb_nonempty", {63'd0, (sb.size() != 0)}, 64'd1);
                if (sb.size() != 0) begin
                    exp_word = sb.pop_front();
                    check_val("out_word", {56'd0, out_data}, {56'd0, exp_word});
                end
                if (out_data != m_prev && m_cnt != (2 ** CNT_W) - 1) begin
                    m_cnt++;
                end
                m_prev = out_data;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_data, mode, mask));
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
        end
    end

    // ------------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and hold it until accepted (bounded).
    task automatic send_word(input logic [WIDTH-1:0] d, input logic [1:0] m,
                             input logic [WIDTH-1:0] k);
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        mode     = m;
        mask     = k;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        check_val("send_accept", {63'd0, done}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            tick();
        end
        tick();
        check_val("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_out_data", {56'd0, out_data}, 64'd0);
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Latency: 3C with mode 00 appears as C3 two cycles after acceptance
        tick();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h3C;
        mode      = 2'b00;
        @(negedge clk);
        check_val("lat_accept", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check_val("lat_n1_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check_val("lat_n2_valid", {63'd0, out_valid}, 64'd1);
        check_val("lat_n2_data", {56'd0, out_data}, 64'hC3);
        drain();

        // Mode patterns
        send_word(8'hAA, 2'b10, 8'h0F);
        send_word(8'h5A, 2'b01, 8'hFF);
        send_word(8'h77, 2'b11, 8'h00);
        send_word(8'h00, 2'b00, 8'h00);
        drain();

        // Back-pressure: fill, hold, release
        out_ready = 1'b0;
        send_word(8'h01, 2'b00, 8'h00);
        send_word(8'h02, 2'b00, 8'h00);
        in_valid = 1'b1;
        in_data  = 8'h03;
        mode     = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("full_in_ready", {63'd0, in_ready}, 64'd0);
            check_val("full_out_data", {56'd0, out_data}, 64'hFE);
        end
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        check_val("full_swap_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        drain();

        // Reset with two words in flight
        out_ready = 1'b0;
        send_word(8'h11, 2'b01, 8'h00);
        send_word(8'h22, 2'b01, 8'h00);
        pulse_reset();
        @(negedge clk);
        check_val("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("flush_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("flush_no_out", {63'd0, out_valid}, 64'd0);
        end
        tick();

`ifdef PARAM_INV_CHGCNT_EN
        // Change counter saturation (CNT_W=2)
        pulse_reset();
        out_ready = 1'b1;
        send_word(8'h00, 2'b01, 8'h00);
        send_word(8'hFF, 2'b01, 8'h00);
        send_word(8'hFF, 2'b01, 8'h00);
        send_word(8'h01, 2'b01, 8'h00);
        send_word(8'h02, 2'b01, 8'h00);
        send_word(8'h03, 2'b01, 8'h00);
        drain();
        check_val("chg_sat", {62'd0, chg_cnt}, 64'd3);
`endif

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            mode      = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom_range(0, 255));
            mask      = 8'($urandom_range(0, 255));
            tick();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
